// File: rtl/arp_rx.sv
// -----------------------------------------------------------------------------
// arp_rx
//
// Purpose:
//   Receives Ethernet frames from a GMII byte stream and picks out ARP
//   requests/replies addressed to this board. A frame is accepted when its
//   preamble/SFD is well formed, the destination MAC is BOARD_MAC or
//   broadcast, the EtherType is ARP (0x0806), the ARP opcode is 1 or 2 and
//   the target protocol address equals BOARD_IP. Padding and FCS are skipped;
//   the FCS is not checked.
//
// Parameters:
//   BOARD_MAC   local MAC address (destination filter)
//   BOARD_IP    local IPv4 address (target-IP filter)
//
// Ports:
//   gmii_rxc     in   GMII receive clock, everything runs on its rising edge
//   rst_n        in   synchronous active-low reset
//   gmii_rx_dv   in   receive data valid
//   gmii_rxd     in   [7:0] receive byte, meaningful while gmii_rx_dv=1
//   arp_rx_done  out  one-cycle pulse when an ARP packet is accepted
//   arp_rx_type  out  0 = request, 1 = reply; held until the next acceptance
//   src_mac      out  [47:0] sender hardware address of the last accepted packet
//   src_ip       out  [31:0] sender protocol address of the last accepted packet
// -----------------------------------------------------------------------------
module arp_rx #(
  parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10}
) (
  input  logic        gmii_rxc,
  input  logic        rst_n,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic        arp_rx_done,
  output logic        arp_rx_type,
  output logic [47:0] src_mac,
  output logic [31:0] src_ip
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    ETH_HEAD = 3'd2,
    ARP_DATA = 3'd3,
    RX_END   = 3'd4
  } state_t;

  localparam logic [7:0]  PRE_BYTE   = 8'h55;
  localparam logic [7:0]  SFD_BYTE   = 8'hD5;
  localparam logic [15:0] ETH_TYPE   = 16'h0806;
  localparam logic [15:0] OP_REQUEST = 16'h0001;
  localparam logic [15:0] OP_REPLY   = 16'h0002;

  state_t      state_reg;
  logic [4:0]  cnt_reg;           // byte counter shared by all states

  // Ethernet header capture
  logic [47:0] eth_dst_reg;
  logic [7:0]  eth_type_hi_reg;

  // ARP payload capture (shadow registers for the sender fields)
  logic [15:0] opcode_reg;
  logic [47:0] sha_reg;
  logic [31:0] spa_reg;
  logic [23:0] tpa_reg;           // first three target-IP bytes; last one is compared live

  // The packet is judged while sampling ARP byte 27; the outputs move one
  // edge later, so the verdict is parked here for a cycle.
  logic        accept_reg;
  logic        accept_type_reg;

  // Checks that combine stored bytes with the byte currently on the bus
  logic dst_ok;
  logic type_ok;
  logic op_ok;
  logic tpa_ok;

  always_comb begin
    dst_ok  = (eth_dst_reg == BOARD_MAC) || (eth_dst_reg == 48'hFFFF_FFFF_FFFF);
    type_ok = ({eth_type_hi_reg, gmii_rxd} == ETH_TYPE);
    op_ok   = (opcode_reg == OP_REQUEST) || (opcode_reg == OP_REPLY);
    tpa_ok  = ({tpa_reg, gmii_rxd} == BOARD_IP);
  end

  always_ff @(posedge gmii_rxc) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      cnt_reg         <= 5'd0;
      eth_dst_reg     <= 48'h0;
      eth_type_hi_reg <= 8'h0;
      opcode_reg      <= 16'h0;
      sha_reg         <= 48'h0;
      spa_reg         <= 32'h0;
      tpa_reg         <= 24'h0;
      accept_reg      <= 1'b0;
      accept_type_reg <= 1'b0;
      arp_rx_done     <= 1'b0;
      arp_rx_type     <= 1'b0;
      src_mac         <= 48'h0;
      src_ip          <= 32'h0;
    end else begin
      // Output stage: publish a verdict made on the previous edge.
      arp_rx_done <= accept_reg;
      accept_reg  <= 1'b0;
      if (accept_reg) begin
        arp_rx_type <= accept_type_reg;
        src_mac     <= sha_reg;
        src_ip      <= spa_reg;
      end

      case (state_reg)
        IDLE: begin
          cnt_reg <= 5'd0;
          if (gmii_rx_dv) begin
            if (gmii_rxd == PRE_BYTE) begin
              state_reg <= PREAMBLE;
              cnt_reg   <= 5'd1;
            end else begin
              // dv is high but this is not the start of a frame (e.g. the
              // tail of a frame interrupted by reset): sit it out.
              state_reg <= RX_END;
            end
          end
        end

        PREAMBLE: begin
          if (!gmii_rx_dv) begin
            state_reg <= IDLE;
            cnt_reg   <= 5'd0;
          end else if ((gmii_rxd == PRE_BYTE) && (cnt_reg < 5'd7)) begin
            cnt_reg <= cnt_reg + 5'd1;
          end else if ((gmii_rxd == SFD_BYTE) && (cnt_reg == 5'd7)) begin
            state_reg <= ETH_HEAD;
            cnt_reg   <= 5'd0;
          end else begin
            // Too few/too many 0x55 bytes or a foreign byte
            state_reg <= RX_END;
            cnt_reg   <= 5'd0;
          end
        end

        ETH_HEAD: begin
          if (!gmii_rx_dv) begin
            state_reg <= IDLE;
            cnt_reg   <= 5'd0;
          end else begin
            cnt_reg <= cnt_reg + 5'd1;
            if (cnt_reg < 5'd6) begin
              eth_dst_reg <= {eth_dst_reg[39:0], gmii_rxd};
            end
            if (cnt_reg == 5'd12) begin
              eth_type_hi_reg <= gmii_rxd;
            end
            if (cnt_reg == 5'd13) begin
              cnt_reg <= 5'd0;
              if (dst_ok && type_ok) begin
                state_reg <= ARP_DATA;
              end else begin
                state_reg <= RX_END;
              end
            end
          end
        end

        ARP_DATA: begin
          if (!gmii_rx_dv) begin
            state_reg <= IDLE;
            cnt_reg   <= 5'd0;
          end else begin
            cnt_reg <= cnt_reg + 5'd1;
            if (cnt_reg == 5'd6) begin
              opcode_reg[15:8] <= gmii_rxd;
            end
            if (cnt_reg == 5'd7) begin
              opcode_reg[7:0] <= gmii_rxd;
            end
            if ((cnt_reg >= 5'd8) && (cnt_reg <= 5'd13)) begin
              sha_reg <= {sha_reg[39:0], gmii_rxd};
            end
            if ((cnt_reg >= 5'd14) && (cnt_reg <= 5'd17)) begin
              spa_reg <= {spa_reg[23:0], gmii_rxd};
            end
            if ((cnt_reg >= 5'd24) && (cnt_reg <= 5'd26)) begin
              tpa_reg <= {tpa_reg[15:0], gmii_rxd};
            end
            if (cnt_reg == 5'd27) begin
              cnt_reg   <= 5'd0;
              state_reg <= RX_END;
              if (op_ok && tpa_ok) begin
                accept_reg      <= 1'b1;
                accept_type_reg <= (opcode_reg == OP_REPLY);
              end
            end
          end
        end

        RX_END: begin
          cnt_reg <= 5'd0;
          if (!gmii_rx_dv) begin
            state_reg <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
          cnt_reg   <= 5'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arp_rx.sv
// -----------------------------------------------------------------------------
// tb_arp_rx
//
// Directed frames are driven into arp_rx. A frame-level model watches the
// same byte stream, judges each dv-high burst as a whole once its 50th byte
// (ARP byte 27) arrives, and predicts the outputs cycle by cycle; a compare
// process checks the DUT against that prediction on every cycle. Literal
// expectations for the key scenarios pin the model.
// -----------------------------------------------------------------------------
module tb_arp_rx;

  localparam logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55;
  localparam logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10};
  localparam logic [47:0] BCAST     = 48'hFFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dv = 1'b0;
  logic [7:0]  rxd = 8'h00;
  logic        done;
  logic        typ;
  logic [47:0] src_mac;
  logic [31:0] src_ip;

  int tests = 0;
  int fails = 0;
  int pulses = 0;

  arp_rx #(.BOARD_MAC(BOARD_MAC), .BOARD_IP(BOARD_IP)) dut (
    .gmii_rxc   (clk),
    .rst_n      (rst_n),
    .gmii_rx_dv (dv),
    .gmii_rxd   (rxd),
    .arp_rx_done(done),
    .arp_rx_type(typ),
    .src_mac    (src_mac),
    .src_ip     (src_ip)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- model
  logic [7:0]  burst[$];
  bit          bad = 1'b1;        // current burst must be ignored (reset hit it)
  bit          pending = 1'b0;
  bit          pend_type = 1'b0;
  logic [47:0] pend_mac = '0;
  logic [31:0] pend_ip = '0;
  logic        exp_done = 1'b0;
  logic        exp_type = 1'b0;
  logic [47:0] exp_mac = '0;
  logic [31:0] exp_ip = '0;

  // Judge a complete 50-byte burst: 8 preamble/SFD, 14 Ethernet, 28 ARP.
  task automatic judge_burst();
    bit          ok;
    logic [47:0] dst, sha;
    logic [31:0] spa, tpa;
    logic [15:0] etype, op;
    ok = 1'b1;
    for (int i = 0; i < 7; i++) if (burst[i] != 8'h55) ok = 1'b0;
    if (burst[7] != 8'hD5) ok = 1'b0;
    dst = '0; sha = '0; spa = '0; tpa = '0;
    for (int i = 0; i < 6; i++) dst = {dst[39:0], burst[8 + i]};
    etype = {burst[20], burst[21]};
    op    = {burst[28], burst[29]};
    for (int i = 0; i < 6; i++) sha = {sha[39:0], burst[30 + i]};
    for (int i = 0; i < 4; i++) spa = {spa[23:0], burst[36 + i]};
    for (int i = 0; i < 4; i++) tpa = {tpa[23:0], burst[46 + i]};
    if (!(dst == BOARD_MAC || dst == BCAST)) ok = 1'b0;
    if (etype != 16'h0806) ok = 1'b0;
    if (!(op == 16'd1 || op == 16'd2)) ok = 1'b0;
    if (tpa != BOARD_IP) ok = 1'b0;
    if (ok) begin
      pending   = 1'b1;
      pend_type = (op == 16'd2);
      pend_mac  = sha;
      pend_ip   = spa;
    end
  endtask

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      exp_done = 1'b0; exp_type = 1'b0; exp_mac = '0; exp_ip = '0;
      pending = 1'b0;
      burst.delete();
      bad = 1'b1;
    end else begin
      exp_done = pending;
      if (pending) begin
        exp_type = pend_type; exp_mac = pend_mac; exp_ip = pend_ip;
      end
      pending = 1'b0;
      if (dv) begin
        if (!bad) begin
          burst.push_back(rxd);
          if (burst.size() == 50) judge_burst();
        end
      end else begin
        burst.delete();
        bad = 1'b0;
      end
    end
  end

  // Cycle-by-cycle compare against the model
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("cyc_done", {63'd0, done}, {63'd0, exp_done});
      chk("cyc_type", {63'd0, typ}, {63'd0, exp_type});
      chk("cyc_src_mac", {16'd0, src_mac}, {16'd0, exp_mac});
      chk("cyc_src_ip", {32'd0, src_ip}, {32'd0, exp_ip});
    end
  end

  initial forever begin
    @(negedge clk);
    if (done === 1'b1) pulses++;
  end

  // ---------------------------------------------------------------- stimulus
  logic [7:0] frame[$];

  task automatic build(input int n55, input logic [47:0] dst, input logic [15:0] etype,
                       input logic [15:0] op, input logic [47:0] smac, input logic [31:0] sip,
                       input logic [31:0] tip, input int pad, input int fcs);
    logic [31:0] fcs_word;
    fcs_word = 32'hDEADBEEF;
    frame.delete();
    repeat (n55) frame.push_back(8'h55);
    frame.push_back(8'hD5);
    for (int i = 5; i >= 0; i--) frame.push_back(dst[8*i +: 8]);
    for (int i = 5; i >= 0; i--) frame.push_back(smac[8*i +: 8]);
    frame.push_back(etype[15:8]); frame.push_back(etype[7:0]);
    frame.push_back(8'h00); frame.push_back(8'h01);
    frame.push_back(8'h08); frame.push_back(8'h00);
    frame.push_back(8'h06); frame.push_back(8'h04);
    frame.push_back(op[15:8]); frame.push_back(op[7:0]);
    for (int i = 5; i >= 0; i--) frame.push_back(smac[8*i +: 8]);
    for (int i = 3; i >= 0; i--) frame.push_back(sip[8*i +: 8]);
    repeat (6) frame.push_back(8'h00);
    for (int i = 3; i >= 0; i--) frame.push_back(tip[8*i +: 8]);
    repeat (pad) frame.push_back(8'h00);
    if (fcs != 0) for (int i = 3; i >= 0; i--) frame.push_back(fcs_word[8*i +: 8]);
  endtask

  task automatic drive(input logic d, input logic [7:0] b);
    @(negedge clk);
    dv = d;
    rxd = b;
  endtask

  // Send frame bytes [0, stop_at) (all when stop_at < 0), then one dv-low cycle.
  task automatic send(input string name, input int stop_at);
    int n;
    n = 0;
    for (int i = 0; i < frame.size(); i++) begin
      if (stop_at >= 0 && i >= stop_at) break;
      drive(1'b1, frame[i]);
      n++;
    end
    drive(1'b0, 8'h00);
    $display("[TB] frame %s: %0d bytes sent", name, n);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00);
  endtask

  int p0;

  initial begin
    // Reset
    rst_n = 1'b0;
    idle(4);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_type", {63'd0, typ}, 64'd0);
    chk("rst_src_mac", {16'd0, src_mac}, 64'd0);
    chk("rst_src_ip", {32'd0, src_ip}, 64'd0);
    rst_n = 1'b1;
    idle(3);

    // Broadcast request
    p0 = pulses;
    build(7, BCAST, 16'h0806, 16'd1, 48'h000A3501FEC0, {8'd192, 8'd168, 8'd1, 8'd102}, BOARD_IP, 0, 0);
    send("bcast_request", -1);
    idle(3);
    chk("req_pulses", 64'(pulses - p0), 64'd1);
    chk("req_type", {63'd0, typ}, 64'd0);
    chk("req_src_mac", {16'd0, src_mac}, 64'h0000_000A3501FEC0);
    chk("req_src_ip", {32'd0, src_ip}, 64'h0000_0000_C0A80166);
    chk("model_req_mac", {16'd0, exp_mac}, 64'h0000_000A3501FEC0);

    // Unicast reply
    p0 = pulses;
    build(7, BOARD_MAC, 16'h0806, 16'd2, 48'h112233AABBCC, {8'd192, 8'd168, 8'd1, 8'd55}, BOARD_IP, 0, 0);
    send("unicast_reply", -1);
    idle(3);
    chk("rep_pulses", 64'(pulses - p0), 64'd1);
    chk("rep_type", {63'd0, typ}, 64'd1);
    chk("rep_src_mac", {16'd0, src_mac}, 64'h0000_112233AABBCC);
    chk("rep_src_ip", {32'd0, src_ip}, 64'h0000_0000_C0A80137);

    // Rejected frames: wrong target IP, IPv4 EtherType, wrong unicast MAC, bad opcode
    p0 = pulses;
    build(7, BCAST, 16'h0806, 16'd1, 48'h0200000000AA, 32'hC0A801AA, {8'd192, 8'd168, 8'd1, 8'd11}, 0, 0);
    send("bad_target_ip", -1);
    build(7, BCAST, 16'h0800, 16'd1, 48'h0200000000AA, 32'hC0A801AA, BOARD_IP, 0, 0);
    send("bad_ethertype", -1);
    build(7, 48'h001122334456, 16'h0806, 16'd1, 48'h0200000000AA, 32'hC0A801AA, BOARD_IP, 0, 0);
    send("bad_dst_mac", -1);
    build(7, BCAST, 16'h0806, 16'd3, 48'h0200000000AA, 32'hC0A801AA, BOARD_IP, 0, 0);
    send("bad_opcode", -1);
    idle(3);
    chk("rej_pulses", 64'(pulses - p0), 64'd0);
    chk("rej_type_held", {63'd0, typ}, 64'd1);
    chk("rej_src_mac_held", {16'd0, src_mac}, 64'h0000_112233AABBCC);
    chk("rej_src_ip_held", {32'd0, src_ip}, 64'h0000_0000_C0A80137);

    // Short preamble, then a valid frame right behind it
    p0 = pulses;
    build(5, BCAST, 16'h0806, 16'd1, 48'h0200000000BB, 32'hC0A801BB, BOARD_IP, 0, 0);
    send("short_preamble", -1);
    build(7, BCAST, 16'h0806, 16'd1, 48'h020000000001, 32'hC0A80101, BOARD_IP, 0, 0);
    send("after_short_pre", -1);
    idle(3);
    chk("shortpre_pulses", 64'(pulses - p0), 64'd1);
    chk("shortpre_src_ip", {32'd0, src_ip}, 64'h0000_0000_C0A80101);

    // dv drops at ARP byte 15 (frame index 8+14+15), then a valid frame
    p0 = pulses;
    build(7, BCAST, 16'h0806, 16'd1, 48'h0200000000CC, 32'hC0A801CC, BOARD_IP, 0, 0);
    send("dv_drop_arp15", 37);
    build(7, BCAST, 16'h0806, 16'd2, 48'h020000000002, 32'hC0A80102, BOARD_IP, 0, 0);
    send("after_dv_drop", -1);
    idle(3);
    chk("dvdrop_pulses", 64'(pulses - p0), 64'd1);
    chk("dvdrop_src_mac", {16'd0, src_mac}, 64'h0000_020000000002);

    // Reset for one cycle at Ethernet byte 4; rest of the frame keeps coming
    p0 = pulses;
    build(7, BCAST, 16'h0806, 16'd1, 48'h0200000000DD, 32'hC0A801DD, BOARD_IP, 0, 0);
    for (int i = 0; i < frame.size(); i++) begin
      @(negedge clk);
      dv = 1'b1;
      rxd = frame[i];
      rst_n = (i == 12) ? 1'b0 : 1'b1;
    end
    drive(1'b0, 8'h00);
    $display("[TB] frame reset_mid_frame: %0d bytes sent", frame.size());
    idle(3);
    chk("rstmid_pulses", 64'(pulses - p0), 64'd0);
    chk("rstmid_src_mac", {16'd0, src_mac}, 64'd0);
    chk("rstmid_src_ip", {32'd0, src_ip}, 64'd0);
    chk("rstmid_type", {63'd0, typ}, 64'd0);
    p0 = pulses;
    build(7, BCAST, 16'h0806, 16'd1, 48'h000A3501FEC1, 32'hC0A80167, BOARD_IP, 0, 0);
    send("after_reset", -1);
    idle(3);
    chk("postrst_pulses", 64'(pulses - p0), 64'd1);
    chk("postrst_src_ip", {32'd0, src_ip}, 64'h0000_0000_C0A80167);

    // Two padded requests with FCS, one dv-low cycle apart
    p0 = pulses;
    build(7, BCAST, 16'h0806, 16'd1, 48'h0200000000E1, {8'd192, 8'd168, 8'd1, 8'd201}, BOARD_IP, 18, 1);
    send("padded_1", -1);
    build(7, BOARD_MAC, 16'h0806, 16'd1, 48'h0200000000E2, {8'd192, 8'd168, 8'd1, 8'd202}, BOARD_IP, 18, 1);
    send("padded_2", -1);
    idle(3);
    chk("b2b_pulses", 64'(pulses - p0), 64'd2);
    chk("b2b_src_mac", {16'd0, src_mac}, 64'h0000_0200000000E2);
    chk("b2b_src_ip", {32'd0, src_ip}, 64'h0000_0000_C0A801CA);
    chk("b2b_type", {63'd0, typ}, 64'd0);

    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/arp_rx.md
ARP_RX -- requirements
Module: arp_rx

Interface
- REQ-001 Parameter BOARD_MAC, default 48'h00_11_22_33_44_55, local MAC address used for destination filtering.
- REQ-002 Parameter BOARD_IP, default {8'd192,8'd168,8'd1,8'd10}, local IPv4 address used for target-IP filtering.
- REQ-003 Port gmii_rxc, input, 1 bit: GMII receive clock; all logic is on its rising edge.
- REQ-004 Port rst_n, input, 1 bit: reset, synchronous to gmii_rxc and active-low.
- REQ-005 Port gmii_rx_dv, input, 1 bit: GMII receive data valid.
- REQ-006 Port gmii_rxd, input, 8 bits: GMII receive byte, valid when gmii_rx_dv=1.
- REQ-007 Port arp_rx_done, output, 1 bit: single-cycle pulse on acceptance of a valid ARP packet.
- REQ-008 Port arp_rx_type, output, 1 bit: 0 = request received, 1 = reply received; valid with arp_rx_done and held until the next accepted packet.
- REQ-009 Port src_mac, output, 48 bits: sender hardware address of the last accepted packet.
- REQ-010 Port src_ip, output, 32 bits: sender protocol address of the last accepted packet.

Function
- REQ-011 The FSM SHALL have states IDLE, PREAMBLE, ETH_HEAD, ARP_DATA and RX_END, with one byte counter shared across states.
- REQ-012 IDLE -> PREAMBLE when gmii_rx_dv=1 and gmii_rxd=8'h55; the counter starts at 1.
- REQ-013 PREAMBLE SHALL accept 6 further bytes of 8'h55 followed by one byte of 8'hD5, then go to ETH_HEAD with the counter cleared.
- REQ-014 Any other preamble byte or count SHALL send the FSM to RX_END.
- REQ-015 ETH_HEAD SHALL take 14 bytes, MSB-first per field.
- REQ-016 In ETH_HEAD, destination MAC (bytes 0-5) SHALL equal BOARD_MAC or 48'hFFFF_FFFF_FFFF.
- REQ-017 In ETH_HEAD, bytes 6-11 (Ethernet source) SHALL be ignored.
- REQ-018 In ETH_HEAD, EtherType (bytes 12-13) SHALL equal 16'h0806.
- REQ-019 The destination MAC and EtherType checks SHALL be evaluated after byte 13; a mismatch goes to RX_END, a pass goes to ARP_DATA with the counter cleared.
- REQ-020 ARP_DATA SHALL take 28 bytes.
- REQ-021 In ARP_DATA, the opcode (bytes 6-7) SHALL be 16'h0001 (request) or 16'h0002 (reply).
- REQ-022 In ARP_DATA, sender MAC (bytes 8-13) and sender IP (bytes 14-17) SHALL be captured into internal shadow registers.
- REQ-023 In ARP_DATA, target IP (bytes 24-27) SHALL equal BOARD_IP.
- REQ-024 In ARP_DATA, all other bytes (hardware/protocol type, lengths, target MAC) SHALL be ignored.
- REQ-025 On sampling ARP byte 27 with a valid opcode and a matching target IP, the block SHALL, on the next rising edge, pulse arp_rx_done=1 for exactly one cycle.
- REQ-026 On that same edge, arp_rx_type SHALL be set to 0 for opcode 1 or 1 for opcode 2.
- REQ-027 On that same edge, src_mac and src_ip SHALL be loaded from the shadow registers.
- REQ-028 After ARP byte 27 the FSM SHALL enter RX_END whether the packet is accepted or rejected.
- REQ-029 An invalid opcode or a target-IP mismatch SHALL produce no pulse and leave the outputs unchanged.
- REQ-030 RX_END SHALL ignore all bytes (padding, FCS) and return to IDLE on the first cycle with gmii_rx_dv=0.
- REQ-031 FCS SHALL NOT be checked.
- REQ-032 gmii_rx_dv=0 in PREAMBLE, ETH_HEAD or ARP_DATA SHALL force IDLE on the next edge, with no pulse and outputs unchanged.
- REQ-033 src_mac, src_ip and arp_rx_type SHALL change only in the arp_rx_done cycle.
- REQ-034 Back-to-back frames separated by at least one dv-low cycle SHALL each be processed independently.
- REQ-035 Latency from the edge sampling ARP byte 27 to arp_rx_done high SHALL be exactly 1 cycle.

Reset
- REQ-036 While rst_n=0 at a rising edge: state=IDLE, counter=0, arp_rx_done=0, arp_rx_type=0, src_mac=48'h0, src_ip=32'h0, shadow registers=0.
- REQ-037 Reset asserted mid-frame SHALL abort the frame with no pulse.
- REQ-038 After release, a frame already in progress (dv=1, no fresh preamble) SHALL NOT be accepted; the FSM waits in IDLE/RX_END for a valid preamble.

Verification
- REQ-039 ARP request, dst FF:FF:FF:FF:FF:FF, sender 00:0A:35:01:FE:C0 / 192.168.1.102, target 192.168.1.10 -> arp_rx_done one-cycle pulse, arp_rx_type=0, src_mac=48'h000A3501FEC0, src_ip=32'hC0A80166.
- REQ-040 ARP reply unicast to BOARD_MAC, opcode 2, target IP matches -> pulse, arp_rx_type=1, outputs updated in the pulse cycle.
- REQ-041 Request with target IP 192.168.1.11, EtherType 16'h0800, or dst MAC 00:11:22:33:44:56 -> no pulse, outputs keep their previous values.
- REQ-042 Preamble with 5 bytes of 0x55 before 0xD5, or dv dropped at ARP byte 15 -> no pulse; an immediately following valid frame -> pulse.
- REQ-043 rst_n=0 for 1 cycle at ETH_HEAD byte 4 -> no pulse, outputs=0; the next full valid frame is accepted.
- REQ-044 Two valid requests with a 1-cycle dv gap and 18 bytes of padding plus 4 bytes of FCS each -> exactly two pulses, the second carrying the second frame's sender fields.
